prefix_decode_ctrl: RTL and testbench
=====================================

// Module: prefix_decode_ctrl
// PURPOSE
//  Sequences the prefix classifier stage of the DNA decode path. Accepts one N-digit word
//  (2 bits/digit, MS digit first), drives the registered classifier, strips the
//  (possibly corrupted) prefix and serially reverses the payload when required.
//  Emits a right-justified payload plus flags over a valid/ready handshake.
// PARAMETERS
//  N      100  max digits per word (word bus is 2*N bits)
//  LEN_W  7    width of length fields; must satisfy 2**LEN_W > N
// PORTS
//  clk                  in   1       single clock, rising edge
//  rst                  in   1       reset, asynchronous, active-high
//  in_valid             in   1       word_in/word_in_len valid
//  in_ready             out  1       controller can accept a word
//  word_in              in   2*N     input word, digits right-justified, MS digit at 2*len-1
//  word_in_len          in   LEN_W   digit count of word_in
//  cls_word             out  2*N     word presented to classifier (held stable)
//  cls_len              out  LEN_W   length presented to classifier
//  cls_reverse_needed   in   1       classifier flag, registered (valid 1 clk after drive)
//  cls_in_prefix        in   1       classifier flag: prefix corrupted, registered
//  out_valid            out  1       result valid; held until out_ready
//  out_ready            in   1       downstream accepts
//  word_out             out  2*N     payload, right-justified, bits >= 2*word_out_len are 0
//  word_out_len         out  LEN_W   payload digit count
//  out_reversed         out  1       payload was digit-reversed
//  out_prefix_err       out  1       prefix was corrupted (1 digit stripped)
//  out_len_err          out  1       input length illegal; payload = input unchanged
// BEHAVIOUR
//  Reset (async): state IDLE; in_ready=1; out_valid=0; all data/flag outputs and regs 0.
//  FSM: IDLE -> CLS_DRV -> CLS_SMP -> {REV | DONE}; REV -> DONE; DONE -> IDLE.
//  IDLE: in_ready=1 only here. in_valid&in_ready latches word/len into wreg/lreg.
//   word_in_len <2 or >N: skip classifier, go DONE with out_len_err=1, payload=word_in, len unchanged.
//  CLS_DRV: cls_word/cls_len = wreg/lreg (held from here until next accept); wait 1 clk.
//  CLS_SMP: sample classifier flags. Strip count s = in_prefix ? 1 : 2.
//   payload = wreg masked to low 2*(lreg-s) bits; plen = lreg-s (may be 0).
//   reverse_needed=1 and plen>0 -> REV, else DONE.
//  REV: counter k=0..plen-1, one digit per clk: dst digit k <= src digit plen-1-k.
//   pure order reversal, no complement; exits to DONE after exactly plen clks.
//  DONE: out_valid=1, outputs stable; out_valid&out_ready -> IDLE (in_ready=1 next clk).
//  Latency accept->out_valid: 3 clks (no reverse), 3+plen clks (reverse), 1 clk (len err).
//  No accept while busy; out_ready ignored outside DONE; out_ready=0 stalls in DONE indefinitely.
//  Flags out_reversed/out_prefix_err = sampled classifier flags (0 when out_len_err).
//  Reset mid-operation (any state incl. REV): aborts word, no output, back to reset values.
// CONFIGURATION
//  PREFIX_STATS_EN defined: adds outputs stat_words, stat_rev, stat_perr (16 b each),
//   incremented on each DONE handshake (words; reversed; prefix-corrupted), saturate at
//   16'hFFFF, cleared by rst only.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING (N=8, classifier model with 1-clk registered output)
//  Len 6 digits 1,4,2,3,1,2 (12'h4B6) -> word_out=8'hB6, len 4, flags 0, out_valid at T+3.
//  Len 6 digits 2,3,1,4,2,3 (12'hB4B) -> payload 8'h4B reversed = 8'hE1, len 4, out_reversed=1, T+7.
//  Len 5 digits 1,2,3,1,2 (10'h1B6) -> prefix_err=1, reversed=0, word_out=8'hB6, len 4.
//  Len 1 or len 9 -> out_len_err=1, payload/len echo input, out_valid at T+1, classifier untouched.
//  out_ready low 10 clks in DONE -> outputs stable, in_ready=0; then accept; back-to-back words ok.
//  rst asserted in REV at k=2 -> out_valid=0, in_ready=1 immediately; next word processes normally.

Source files
------------

// File: rtl/prefix_decode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prefix_decode_ctrl                                                         |
// | Prefix classifier sequencer: strips the prefix, optionally digit-reverses  |
// | the payload. Optional counters are enabled by the PREFIX_STATS_EN macro.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prefix_decode_ctrl #(
  parameter int N     = 100,
  parameter int LEN_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     word_in,
  input  logic [LEN_W-1:0]   word_in_len,
  output logic [2*N-1:0]     cls_word,
  output logic [LEN_W-1:0]   cls_len,
  input  logic               cls_reverse_needed,
  input  logic               cls_in_prefix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     word_out,
  output logic [LEN_W-1:0]   word_out_len,
  output logic               out_reversed,
  output logic               out_prefix_err,
  output logic               out_len_err
`ifdef PREFIX_STATS_EN
  ,
  output logic [15:0]        stat_words,
  output logic [15:0]        stat_rev,
  output logic [15:0]        stat_perr
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLS_DRV = 3'd1,
    S_CLS_SMP = 3'd2,
    S_REV     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] c_min_len = LEN_W'(2);
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(N);
  localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_two     = LEN_W'(2);

  state_t           r_state;
  logic [2*N-1:0]   r_src;
  logic [LEN_W-1:0] r_plen;
  logic [LEN_W-1:0] r_k;

  logic             w_len_bad;
  logic [LEN_W-1:0] w_plen;
  logic [2*N-1:0]   w_mask;
  logic [2*N-1:0]   w_payload;
  logic [LEN_W:0]   w_src_idx;
  logic [LEN_W:0]   w_dst_idx;

  assign w_len_bad = (word_in_len < c_min_len) || (word_in_len > c_max_len);

  // cls_word/cls_len double as the latched word: they only change on a legal accept
  assign w_plen    = cls_len - (cls_in_prefix ? c_one : c_two);
  assign w_mask    = ~({(2*N){1'b1}} << {w_plen, 1'b0});
  assign w_payload = cls_word & w_mask;
  assign w_src_idx = {r_plen - r_k - c_one, 1'b0};
  assign w_dst_idx = {r_k, 1'b0};

`ifdef PREFIX_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_src          <= '0;
      r_plen         <= '0;
      r_k            <= '0;
      in_ready       <= 1'b1;
      cls_word       <= '0;
      cls_len        <= '0;
      out_valid      <= 1'b0;
      word_out       <= '0;
      word_out_len   <= '0;
      out_reversed   <= 1'b0;
      out_prefix_err <= 1'b0;
      out_len_err    <= 1'b0;
`ifdef PREFIX_STATS_EN
      stat_words     <= '0;
      stat_rev       <= '0;
      stat_perr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (w_len_bad) begin
              word_out       <= word_in;
              word_out_len   <= word_in_len;
              out_len_err    <= 1'b1;
              out_reversed   <= 1'b0;
              out_prefix_err <= 1'b0;
              out_valid      <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              cls_word <= word_in;
              cls_len  <= word_in_len;
              r_state  <= S_CLS_DRV;
            end
          end
        end
        S_CLS_DRV: r_state <= S_CLS_SMP;
        S_CLS_SMP: begin
          out_reversed   <= cls_reverse_needed;
          out_prefix_err <= cls_in_prefix;
          out_len_err    <= 1'b0;
          word_out_len   <= w_plen;
          r_plen         <= w_plen;
          r_k            <= '0;
          if (cls_reverse_needed && (w_plen != '0)) begin
            r_src    <= w_payload;
            word_out <= '0;
            r_state  <= S_REV;
          end else begin
            word_out  <= w_payload;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_REV: begin
          word_out[w_dst_idx +: 2] <= r_src[w_src_idx +: 2];
          r_k <= r_k + c_one;
          if (r_k == r_plen - c_one) begin
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
`ifdef PREFIX_STATS_EN
            stat_words <= sat_inc(stat_words);
            if (out_reversed)   stat_rev  <= sat_inc(stat_rev);
            if (out_prefix_err) stat_perr <= sat_inc(stat_perr);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prefix_decode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prefix_decode_ctrl                                                      |
// | Directed scoreboard bench for prefix_decode_ctrl (N=8) with a registered   |
// | classifier model.                                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_prefix_decode_ctrl;

  localparam int N     = 8;
  localparam int LEN_W = 4;

  typedef struct {
    logic [2*N-1:0]   word;
    logic [LEN_W-1:0] len;
    logic             rev;
    logic             perr;
    logic             lerr;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2*N-1:0]   word_in = '0;
  logic [LEN_W-1:0] word_in_len = '0;
  logic [2*N-1:0]   cls_word;
  logic [LEN_W-1:0] cls_len;
  logic             cls_reverse_needed = 1'b0;
  logic             cls_in_prefix = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*N-1:0]   word_out;
  logic [LEN_W-1:0] word_out_len;
  logic             out_reversed;
  logic             out_prefix_err;
  logic             out_len_err;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  prefix_decode_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .word_in(word_in), .word_in_len(word_in_len),
    .cls_word(cls_word), .cls_len(cls_len),
    .cls_reverse_needed(cls_reverse_needed), .cls_in_prefix(cls_in_prefix),
    .out_valid(out_valid), .out_ready(out_ready),
    .word_out(word_out), .word_out_len(word_out_len),
    .out_reversed(out_reversed), .out_prefix_err(out_prefix_err),
    .out_len_err(out_len_err)
  );

  always #5 clk = ~clk;

  // Classifier stand-in keyed on the two leading digits, one clock of latency
  logic [3:0] cls_top;
  always_comb begin
    int sh;
    sh = 2 * int'(cls_len) - 4;
    cls_top = (sh >= 0) ? 4'(cls_word >> sh) : 4'd0;
  end
  always @(posedge clk) begin
    case (cls_top)
      4'b0100: {cls_reverse_needed, cls_in_prefix} <= 2'b00;
      4'b1011: {cls_reverse_needed, cls_in_prefix} <= 2'b10;
      4'b1110: {cls_reverse_needed, cls_in_prefix} <= 2'b11;
      default: {cls_reverse_needed, cls_in_prefix} <= 2'b01;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2*N-1:0] w, input logic [LEN_W-1:0] l,
                      input logic r, input logic p, input logic e, input int lat);
    exp_t x;
    x.word = w; x.len = l; x.rev = r; x.perr = p; x.lerr = e; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic accept(input logic [2*N-1:0] w, input logic [LEN_W-1:0] l);
    int n;
    @(negedge clk);
    word_in = w; word_in_len = l; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall);
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    check("latency",     32'(lat),            32'(e.lat));
    check("out_valid",   32'(out_valid),      32'd1);
    check("word_out",    32'(word_out),       32'(e.word));
    check("word_out_len",32'(word_out_len),   32'(e.len));
    check("out_reversed",32'(out_reversed),   32'(e.rev));
    check("prefix_err",  32'(out_prefix_err), 32'(e.perr));
    check("len_err",     32'(out_len_err),    32'(e.lerr));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready),  32'd0);
      check("stall_word",  32'(word_out),  32'(e.word));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready),  32'd1);
  endtask

  task automatic xfer(input logic [2*N-1:0] w, input logic [LEN_W-1:0] l,
                      input logic [2*N-1:0] ew, input logic [LEN_W-1:0] el,
                      input logic r, input logic p, input logic e, input int lat,
                      input int stall);
    push(ew, el, r, p, e, lat);
    accept(w, l);
    collect(stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_word_out",  32'(word_out),     32'd0);
    check("rst_len",       32'(word_out_len), 32'd0);
    check("rst_flags",     32'({out_reversed, out_prefix_err, out_len_err}), 32'd0);
    check("rst_cls_word",  32'(cls_word),     32'd0);
    @(negedge clk); rst = 1'b0;

    // word, len, exp word, exp len, rev, perr, lerr, latency, stall
    xfer(16'h04B6, 4'd6, 16'h00B6, 4'd4, 1'b0, 1'b0, 1'b0, 3,  0);
    xfer(16'h0B4B, 4'd6, 16'h00E1, 4'd4, 1'b1, 1'b0, 1'b0, 7,  0);
    xfer(16'h01B6, 4'd5, 16'h00B6, 4'd4, 1'b0, 1'b1, 1'b0, 3,  10);
    xfer(16'h0003, 4'd1, 16'h0003, 4'd1, 1'b0, 1'b0, 1'b1, 1,  0);
    check("cls_word_held", 32'(cls_word), 32'h01B6);
    check("cls_len_held",  32'(cls_len),  32'd5);
    xfer(16'hFFFF, 4'd9, 16'hFFFF, 4'd9, 1'b0, 1'b0, 1'b1, 1,  0);
    xfer(16'h0000, 4'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1,  0);
    check("cls_word_held2", 32'(cls_word), 32'h01B6);
    xfer(16'h000B, 4'd2, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 3,  0);
    xfer(16'hE1B6, 4'd8, 16'h2792, 4'd7, 1'b1, 1'b1, 1'b0, 10, 2);

    // Abort in the middle of reversal (k=2), then a normal word
    accept(16'h0B4B, 4'd6);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_word_out",  32'(word_out),  32'd0);
    check("abort_len",       32'(word_out_len), 32'd0);
    @(negedge clk); rst = 1'b0;
    xfer(16'h04B6, 4'd6, 16'h00B6, 4'd4, 1'b0, 1'b0, 1'b0, 3,  0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
